// File: rtl/vga_pkg.sv
// Shared SVGA 800x600@60 timing constants, vertical state and colour-bar palette.
package vga_pkg;

  localparam logic [10:0] H_ACTIVE = 11'd800;
  localparam logic [10:0] H_FP     = 11'd40;
  localparam logic [10:0] H_SYNC   = 11'd128;
  localparam logic [10:0] H_BP     = 11'd88;
  localparam logic [10:0] H_TOTAL  =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [10:0] H_LAST   = H_TOTAL - 11'd1;
  localparam logic [10:0] HS_START = H_ACTIVE + H_FP;
  localparam logic [10:0] HS_END   = HS_START + H_SYNC;

  // Vertical lengths carry a suffix so they do not collide with vstate_t names
  localparam logic [9:0] V_ACTIVE   = 10'd600;
  localparam logic [9:0] V_FP_LEN   = 10'd1;
  localparam logic [9:0] V_SYNC_LEN = 10'd4;
  localparam logic [9:0] V_BP_LEN   = 10'd23;
  localparam logic [9:0] V_TOTAL    =
    V_ACTIVE + V_FP_LEN + V_SYNC_LEN + V_BP_LEN;
  localparam logic [9:0] V_ACT_LAST  = V_ACTIVE - 10'd1;
  localparam logic [9:0] V_FP_LAST   = V_ACT_LAST + V_FP_LEN;
  localparam logic [9:0] V_SYNC_LAST = V_FP_LAST + V_SYNC_LEN;
  localparam logic [9:0] V_LAST      = V_TOTAL - 10'd1;

  typedef enum logic [1:0] {
    V_ACT,
    V_FP,
    V_SYNC,
    V_BP
  } vstate_t;

  localparam logic [10:0] BAR_W = H_ACTIVE >> 3;

  localparam logic [11:0] C_WHITE   = 12'hFFF;
  localparam logic [11:0] C_YELLOW  = 12'hFF0;
  localparam logic [11:0] C_CYAN    = 12'h0FF;
  localparam logic [11:0] C_GREEN   = 12'h0F0;
  localparam logic [11:0] C_MAGENTA = 12'hF0F;
  localparam logic [11:0] C_RED     = 12'hF00;
  localparam logic [11:0] C_BLUE    = 12'h00F;
  localparam logic [11:0] C_BLACK   = 12'h000;

  function automatic logic [11:0] bar_colour(
    input logic [10:0] h
  );
    logic [11:0] c;
    c = C_BLACK;
    if (h < BAR_W)               c = C_WHITE;
    else if (h < BAR_W * 11'd2)  c = C_YELLOW;
    else if (h < BAR_W * 11'd3)  c = C_CYAN;
    else if (h < BAR_W * 11'd4)  c = C_GREEN;
    else if (h < BAR_W * 11'd5)  c = C_MAGENTA;
    else if (h < BAR_W * 11'd6)  c = C_RED;
    else if (h < BAR_W * 11'd7)  c = C_BLUE;
    return c;
  endfunction

endpackage

// File: rtl/vga_vcounter.sv
// Vertical line counter and porch/sync state machine.
// Both advance only on the line-end strobe.
module vga_vcounter
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [9:0] v_count,
  output vstate_t    vstate
);

  logic [9:0] v_count_n;
  vstate_t    vstate_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_count <= '0;
      vstate  <= V_ACT;
    end else begin
      v_count <= v_count_n;
      vstate  <= vstate_n;
    end
  end

  always_comb begin
    v_count_n = v_count;
    vstate_n  = vstate;
    if (step) begin
      v_count_n = (v_count == V_LAST) ?
        10'd0 : v_count + 10'd1;
      // leave each phase on the line end of its final line
      unique case (vstate)
        V_ACT:
          if (v_count == V_ACT_LAST)  vstate_n = V_FP;
        V_FP:
          if (v_count == V_FP_LAST)   vstate_n = V_SYNC;
        V_SYNC:
          if (v_count == V_SYNC_LAST) vstate_n = V_BP;
        V_BP:
          if (v_count == V_LAST)      vstate_n = V_ACT;
      endcase
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Sync/enable/coordinate generator driven by an upstream h counter.
// Define VGA_TEST_PATTERN_EN to add the rgb colour-bar output.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_count,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        h_err
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0] rgb
`endif
);

  logic [9:0] v_count;
  vstate_t    vstate;
  logic       in_range;
  logic       line_end;
  logic       de_h;
  logic       hs_on;
  logic       de_n;
  logic       h_zero;

  assign in_range = h_count < H_TOTAL;
  assign line_end = en & (h_count == H_LAST);
  assign de_h     = h_count < H_ACTIVE;
  assign hs_on    = (h_count >= HS_START) &
                    (h_count < HS_END);
  assign de_n     = de_h & (vstate == V_ACT);
  assign h_zero   = h_count == 11'd0;

  vga_vcounter u_vcnt (
    .clk     (clk),
    .rst     (rst),
    .step    (line_end),
    .v_count (v_count),
    .vstate  (vstate)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
    end else if (en) begin
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= (vstate == V_SYNC) ?
                     VS_POL : ~VS_POL;
      de          <= de_n;
      pix_x       <= de_n ? h_count : '0;
      pix_y       <= de_n ? v_count : '0;
      line_start  <= h_zero;
      frame_start <= h_zero & (v_count == 10'd0);
      h_err       <= h_err | ~in_range;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rgb <= '0;
    else if (en)
      rgb <= de_n ? bar_colour(h_count) : '0;
  end
`endif

endmodule
